// File: rtl/hssl_pkg.sv
// Shared types and constants for the HSSL link monitor.
package hssl_pkg;

  localparam int unsigned FRM_W = 32;
  localparam int unsigned DEC_W = 16;

  typedef logic [1:0] link_state_t;

  localparam link_state_t LS_DOWN = 2'd0;
  localparam link_state_t LS_SYNC = 2'd1;
  localparam link_state_t LS_UP   = 2'd2;

  // A frame is good when it is strobed and its CRC passed.
  function automatic logic is_good(input logic vld, input logic err);
    return vld & ~err;
  endfunction

endpackage

// File: rtl/hssl_link_monitor_if.sv
// Receive-side status inputs and published link/counter outputs of the link monitor.
interface hssl_link_monitor_if;
  import hssl_pkg::*;

  logic              rx_aligned;
  logic              frame_vld;
  logic              frame_err;
  logic              dec_err;
  logic              clear_async;
  link_state_t       link_state;
  logic [FRM_W-1:0]  frames_snap;
  logic [FRM_W-1:0]  errs_snap;
  logic [DEC_W-1:0]  dec_snap;
  logic [DEC_W-1:0]  loss_snap;
  logic              snap_tgl;

  modport master (
    output rx_aligned, frame_vld, frame_err, dec_err, clear_async,
    input  link_state, frames_snap, errs_snap, dec_snap, loss_snap, snap_tgl
  );

  modport slave (
    input  rx_aligned, frame_vld, frame_err, dec_err, clear_async,
    output link_state, frames_snap, errs_snap, dec_snap, loss_snap, snap_tgl
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop single-bit synchroniser into the clk domain.
module bit_synchronizer (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [1:0] r_sync;

  // shift the asynchronous level through two flops
  always_ff @(posedge clk) begin
    if (!resetn) r_sync <= '0;
    else         r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with clear priority; exposes the value it will load next
// so snapshots can include a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q_nxt
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_nxt;

  // next value: clear wins, otherwise increment until all-ones
  always_comb begin
    w_nxt = r_q;
    if (i_clr)                 w_nxt = '0;
    else if (i_inc && !(&r_q)) w_nxt = r_q + W'(1);
  end

  // live count register
  always_ff @(posedge clk) begin
    if (!resetn) r_q <= '0;
    else         r_q <= w_nxt;
  end

  assign o_q_nxt = w_nxt;

endmodule

// File: rtl/hssl_link_monitor.sv
// HSSL receive link-health monitor: link FSM, saturating counters with
// synchronised clear, and periodic snapshots held stable for a full period.
module hssl_link_monitor
  import hssl_pkg::*;
#(
  parameter int unsigned SNAP_LOG2   = 16,
  parameter int unsigned GOOD_THRESH = 8,
  parameter int unsigned ERR_THRESH  = 4
) (
  input logic               clk,
  input logic               resetn,
  hssl_link_monitor_if.slave lnk
);

  link_state_t          r_state;
  logic [7:0]           r_good_run;
  logic [7:0]           r_bad_run;
  logic                 r_clr_d;
  logic [SNAP_LOG2-1:0] r_per;
  logic                 r_tgl;
  logic [FRM_W-1:0]     r_frames_snap;
  logic [FRM_W-1:0]     r_errs_snap;
  logic [DEC_W-1:0]     r_dec_snap;
  logic [DEC_W-1:0]     r_loss_snap;

  logic                 w_good;
  logic                 w_bad;
  logic                 w_loss;
  logic                 w_clr_sync;
  logic                 w_clr_edge;
  logic                 w_wrap;
  logic [7:0]           w_good_nxt;
  logic [7:0]           w_bad_nxt;
  logic [FRM_W-1:0]     w_frm_nxt;
  logic [FRM_W-1:0]     w_err_nxt;
  logic [DEC_W-1:0]     w_dec_nxt;
  logic [DEC_W-1:0]     w_loss_nxt;

  assign w_good     = is_good(lnk.frame_vld, lnk.frame_err);
  assign w_bad      = lnk.frame_vld & lnk.frame_err;
  assign w_loss     = (r_state == LS_UP) & ~lnk.rx_aligned;
  assign w_good_nxt = r_good_run + 8'd1;
  assign w_bad_nxt  = r_bad_run + 8'd1;
  assign w_wrap     = &r_per;

  // link state machine with good/bad run counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= LS_DOWN;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else begin
      case (r_state)
        LS_DOWN: begin
          if (lnk.rx_aligned) begin
            r_state    <= LS_SYNC;
            r_good_run <= '0;
          end
        end
        LS_SYNC: begin
          if (!lnk.rx_aligned) begin
            r_state <= LS_DOWN;
          end else if (w_bad) begin
            r_good_run <= '0;
          end else if (w_good) begin
            r_good_run <= w_good_nxt;
            if (w_good_nxt == 8'(GOOD_THRESH)) begin
              r_state   <= LS_UP;
              r_bad_run <= '0;
            end
          end
        end
        LS_UP: begin
          if (!lnk.rx_aligned) begin
            r_state <= LS_DOWN;
          end else if (w_bad) begin
            r_bad_run <= w_bad_nxt;
            if (w_bad_nxt == 8'(ERR_THRESH)) begin
              r_state    <= LS_SYNC;
              r_good_run <= '0;
            end
          end else if (w_good) begin
            r_bad_run <= '0;
          end
        end
        default: r_state <= LS_DOWN;
      endcase
    end
  end

  bit_synchronizer u_clr_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (lnk.clear_async),
    .o_q    (w_clr_sync)
  );

  // remember the synchronised clear level for rising-edge detection
  always_ff @(posedge clk) begin
    if (!resetn) r_clr_d <= 1'b0;
    else         r_clr_d <= w_clr_sync;
  end

  assign w_clr_edge = w_clr_sync & ~r_clr_d;

  sat_counter #(.W(FRM_W)) u_frm_cnt (
    .clk(clk), .resetn(resetn), .i_inc(w_good), .i_clr(w_clr_edge), .o_q_nxt(w_frm_nxt)
  );
  sat_counter #(.W(FRM_W)) u_err_cnt (
    .clk(clk), .resetn(resetn), .i_inc(w_bad), .i_clr(w_clr_edge), .o_q_nxt(w_err_nxt)
  );
  sat_counter #(.W(DEC_W)) u_dec_cnt (
    .clk(clk), .resetn(resetn), .i_inc(lnk.dec_err), .i_clr(w_clr_edge), .o_q_nxt(w_dec_nxt)
  );
  sat_counter #(.W(DEC_W)) u_loss_cnt (
    .clk(clk), .resetn(resetn), .i_inc(w_loss), .i_clr(w_clr_edge), .o_q_nxt(w_loss_nxt)
  );

  // free-running period counter; on wrap publish the counters' next values
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_per         <= '0;
      r_tgl         <= 1'b0;
      r_frames_snap <= '0;
      r_errs_snap   <= '0;
      r_dec_snap    <= '0;
      r_loss_snap   <= '0;
    end else begin
      r_per <= r_per + SNAP_LOG2'(1);
      if (w_wrap) begin
        r_frames_snap <= w_frm_nxt;
        r_errs_snap   <= w_err_nxt;
        r_dec_snap    <= w_dec_nxt;
        r_loss_snap   <= w_loss_nxt;
        r_tgl         <= ~r_tgl;
      end
    end
  end

  assign lnk.link_state  = r_state;
  assign lnk.frames_snap = r_frames_snap;
  assign lnk.errs_snap   = r_errs_snap;
  assign lnk.dec_snap    = r_dec_snap;
  assign lnk.loss_snap   = r_loss_snap;
  assign lnk.snap_tgl    = r_tgl;

endmodule

// File: tb/tb_hssl_link_monitor.sv
// Directed bench for hssl_link_monitor with a behavioural reference model.
module tb_hssl_link_monitor;

  localparam int unsigned SL2    = 4;
  localparam int unsigned GT     = 8;
  localparam int unsigned ET     = 4;
  localparam int          PERIOD = 1 << SL2;
  localparam longint      MAX32  = 64'hFFFF_FFFF;
  localparam longint      MAX16  = 64'hFFFF;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hssl_link_monitor_if lnk ();

  hssl_link_monitor #(
    .SNAP_LOG2   (SL2),
    .GOOD_THRESH (GT),
    .ERR_THRESH  (ET)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .lnk    (lnk)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_state;
  int     m_good_run, m_bad_run;
  longint m_frm, m_err, m_dec, m_loss;
  longint s_frm, s_err, s_dec, s_loss;
  bit     s_tgl;
  int     m_n;
  bit [2:0] m_ch;
  bit     m_valid = 1'b0;

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    bit good, bad, rx, clr;
    if (!resetn) begin
      m_state = 0; m_good_run = 0; m_bad_run = 0;
      m_frm = 0; m_err = 0; m_dec = 0; m_loss = 0;
      s_frm = 0; s_err = 0; s_dec = 0; s_loss = 0; s_tgl = 1'b0;
      m_n = 0; m_ch = '0;
    end else begin
      rx   = lnk.rx_aligned;
      good = lnk.frame_vld && !lnk.frame_err;
      bad  = lnk.frame_vld && lnk.frame_err;
      // clear level seen two and three edges ago (two-flop delay, then rising edge)
      clr  = m_ch[1] && !m_ch[2];
      m_ch = {m_ch[1], m_ch[0], lnk.clear_async};

      if (m_state == 2 && !rx) m_loss = sat_inc(m_loss, MAX16);
      if (good)        m_frm = sat_inc(m_frm, MAX32);
      if (bad)         m_err = sat_inc(m_err, MAX32);
      if (lnk.dec_err) m_dec = sat_inc(m_dec, MAX16);
      if (clr) begin m_frm = 0; m_err = 0; m_dec = 0; m_loss = 0; end

      case (m_state)
        0: if (rx) begin m_state = 1; m_good_run = 0; end
        1: begin
          if (!rx) m_state = 0;
          else if (bad) m_good_run = 0;
          else if (good) begin
            m_good_run++;
            if (m_good_run == GT) begin m_state = 2; m_bad_run = 0; end
          end
        end
        default: begin
          if (!rx) m_state = 0;
          else if (bad) begin
            m_bad_run++;
            if (m_bad_run == ET) begin m_state = 1; m_good_run = 0; end
          end else if (good) m_bad_run = 0;
        end
      endcase

      m_n++;
      if (m_n % PERIOD == 0) begin
        s_frm = m_frm; s_err = m_err; s_dec = m_dec; s_loss = m_loss;
        s_tgl = ~s_tgl;
      end
    end
    m_valid = 1'b1;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("link_state",  lnk.link_state,  m_state);
      chk("frames_snap", lnk.frames_snap, s_frm);
      chk("errs_snap",   lnk.errs_snap,   s_err);
      chk("dec_snap",    lnk.dec_snap,    s_dec);
      chk("loss_snap",   lnk.loss_snap,   s_loss);
      chk("snap_tgl",    lnk.snap_tgl,    s_tgl);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_snap(output int cycles);
    logic t0;
    t0 = lnk.snap_tgl;
    cycles = 0;
    while (lnk.snap_tgl == t0 && cycles < 3 * PERIOD) begin
      step();
      cycles++;
    end
    chk("snap_tgl_changed", lnk.snap_tgl != t0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    resetn = 1'b0;
    lnk.rx_aligned = 1'b0; lnk.frame_vld = 1'b0; lnk.frame_err = 1'b0;
    lnk.dec_err = 1'b0; lnk.clear_async = 1'b0;
    repeat (3) step();
    chk("lit_reset_state", lnk.link_state, 0);
    chk("lit_reset_tgl",   lnk.snap_tgl,   0);
    chk("lit_reset_frm",   lnk.frames_snap, 0);

    // bring-up: DOWN -> SYNC -> UP after 8 good frames
    resetn = 1'b1; lnk.rx_aligned = 1'b1;
    step();
    chk("lit_sync", lnk.link_state, 1);
    lnk.frame_vld = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) chk("lit_still_sync", lnk.link_state, 1);
      if (i == 8) chk("lit_up", lnk.link_state, 2);
    end
    lnk.frame_vld = 1'b0;
    wait_snap(c);
    chk("lit_frames_8", lnk.frames_snap, 8);

    // 3 bad, 1 good, 4 bad: UP held until 4th consecutive bad
    lnk.frame_vld = 1'b1; lnk.frame_err = 1'b1;
    repeat (3) step();
    lnk.frame_err = 1'b0; step();
    lnk.frame_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lit_bad_run_state", lnk.link_state, (i == 3) ? 1 : 2);
    end
    lnk.frame_vld = 1'b0; lnk.frame_err = 1'b0;
    wait_snap(c);
    chk("lit_errs_7",   lnk.errs_snap,   7);
    chk("lit_frames_9", lnk.frames_snap, 9);

    // back to UP, then lose alignment with a good frame in flight
    lnk.frame_vld = 1'b1;
    repeat (8) step();
    chk("lit_up_again", lnk.link_state, 2);
    lnk.rx_aligned = 1'b0;
    step();
    chk("lit_down_loss", lnk.link_state, 0);
    lnk.frame_vld = 1'b0;
    wait_snap(c);
    chk("lit_loss_1",    lnk.loss_snap,   1);
    chk("lit_frames_18", lnk.frames_snap, 18);

    // clear raised together with a good frame; held high afterwards
    lnk.frame_vld = 1'b1; lnk.clear_async = 1'b1;
    step();
    lnk.frame_vld = 1'b0;
    chk("lit_snap_holds_old", lnk.frames_snap, 18);
    repeat (3) step();
    lnk.frame_vld = 1'b1;
    repeat (2) step();
    lnk.frame_vld = 1'b0;
    wait_snap(c);
    chk("lit_frames_after_clr", lnk.frames_snap, 2);
    chk("lit_errs_after_clr",   lnk.errs_snap,   0);
    chk("lit_loss_after_clr",   lnk.loss_snap,   0);
    wait_snap(c);
    chk("lit_held_clr_no_reclear", lnk.frames_snap, 2);
    lnk.clear_async = 1'b0;

    // continuous decode errors: toggle every PERIOD, dec_snap steps by PERIOD
    lnk.dec_err = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_snap(c);
      chk("lit_tgl_interval", c, PERIOD);
      chk("lit_dec_step", lnk.dec_snap, 16 * k);
    end
    lnk.dec_err = 1'b0;

    // saturation of the frame counter
    force dut.u_frm_cnt.r_q = 32'hFFFF_FFFE;
    m_frm = 64'hFFFF_FFFE;
    step();
    release dut.u_frm_cnt.r_q;
    lnk.frame_vld = 1'b1;
    repeat (3) step();
    lnk.frame_vld = 1'b0;
    wait_snap(c);
    chk("lit_frames_sat", lnk.frames_snap, 64'hFFFF_FFFF);

    // reset in the middle of activity
    lnk.rx_aligned = 1'b1; lnk.frame_vld = 1'b1; lnk.dec_err = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    step();
    chk("lit_midrst_state", lnk.link_state,  0);
    chk("lit_midrst_frm",   lnk.frames_snap, 0);
    chk("lit_midrst_dec",   lnk.dec_snap,    0);
    chk("lit_midrst_tgl",   lnk.snap_tgl,    0);
    lnk.rx_aligned = 1'b0; lnk.frame_vld = 1'b0; lnk.dec_err = 1'b0;
    resetn = 1'b1;
    wait_snap(c);
    chk("lit_first_snap_after_rst", c, PERIOD);
    chk("lit_frm_after_rst", lnk.frames_snap, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
